// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the 4:1 mux select scanner.
package mux_scan_pkg;

  localparam int unsigned CH_N  = 4;
  localparam int unsigned SEL_W = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    DWELL = 1'b1
  } state_e;

  // Index of the lowest set bit of m; 0 when m is empty.
  function automatic logic [SEL_W-1:0] first_set(input logic [CH_N-1:0] m);
    first_set = '0;
    for (int unsigned i = CH_N; i > 0; i--) begin
      if (m[i-1]) first_set = SEL_W'(i - 1);
    end
  endfunction

endpackage

// File: rtl/mux_select_scanner_next_ch_find.sv
// Combinational search for the next enabled channel above the current one.
// When none exists, wrap_o is set and next_o is the lowest enabled channel.
module next_ch_find
  import mux_scan_pkg::*;
(
  input  logic [CH_N-1:0]  mask_i,
  input  logic [SEL_W-1:0] cur_i,
  output logic [SEL_W-1:0] next_o,
  output logic             wrap_o
);

  // Descending scan so the lowest qualifying index is the one kept.
  always_comb begin
    next_o = first_set(mask_i);
    wrap_o = 1'b1;
    for (int unsigned i = CH_N; i > 0; i--) begin
      if (mask_i[i-1] && ((i - 1) > 32'(cur_i))) begin
        next_o = SEL_W'(i - 1);
        wrap_o = 1'b0;
      end
    end
  end

endmodule

// File: rtl/mux_select_scanner.sv
// Sweeps the select of a downstream 4:1 mux over the enabled channels,
// holding each for max(dwell,1) cycles; one-shot or continuous.
module mux_select_scanner
  import mux_scan_pkg::*;
#(
  parameter int unsigned DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic [3:0]         mask,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               continuous,
  output logic [1:0]         s,
  output logic               valid,
  output logic               busy,
  output logic               sweep_done,
  output logic               err
);

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   s_q, s_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [DWELL_W-1:0] reload_q, reload_d;
  logic [CH_N-1:0]    mask_q, mask_d;
  logic               cont_q, cont_d;

  logic [SEL_W-1:0]   nxt;
  logic               wrap;
  logic               start_ok;
  logic               expire;
  logic [DWELL_W-1:0] dwell_m1;

  next_ch_find u_find (
    .mask_i (mask_q),
    .cur_i  (s_q),
    .next_o (nxt),
    .wrap_o (wrap)
  );

  assign start_ok = start && (mask != '0);
  assign expire   = (cnt_q == '0);
  // Latched as max(dwell,1)-1 so a zero dwell needs no later special case.
  assign dwell_m1 = (dwell == '0) ? '0 : dwell - DWELL_W'(1);

  // State and registered outputs/config, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      s_q      <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
      reload_q <= '0;
      mask_q   <= '0;
      cont_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      s_q      <= s_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
      reload_q <= reload_d;
      mask_q   <= mask_d;
      cont_q   <= cont_d;
    end
  end

  // Next state: stop outranks expiry; one-shot wrap returns to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_ok) state_d = DWELL;
      DWELL: begin
        if (stop)                           state_d = IDLE;
        else if (expire && wrap && !cont_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Next values of select, counter, latched config and output pulses.
  always_comb begin
    s_d      = s_q;
    cnt_d    = cnt_q;
    reload_d = reload_q;
    mask_d   = mask_q;
    cont_d   = cont_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    valid_d  = (state_d == DWELL);
    busy_d   = (state_d == DWELL);
    case (state_q)
      IDLE: begin
        if (start_ok) begin
          mask_d   = mask;
          cont_d   = continuous;
          reload_d = dwell_m1;
          cnt_d    = dwell_m1;
          s_d      = first_set(mask);
        end else if (start) begin
          err_d = 1'b1;
        end
      end
      DWELL: begin
        if (stop) begin
          s_d   = '0;
          cnt_d = '0;
        end else if (!expire) begin
          cnt_d = cnt_q - DWELL_W'(1);
        end else begin
          s_d   = nxt;
          cnt_d = reload_q;
          if (wrap) begin
            done_d = 1'b1;
            if (!cont_q) begin
              s_d   = '0;
              cnt_d = '0;
            end
          end
        end
      end
      default: ;
    endcase
  end

  assign s          = s_q;
  assign valid      = valid_q;
  assign busy       = busy_q;
  assign sweep_done = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_mux_select_scanner.sv
// Self-checking bench for mux_select_scanner: directed scenarios plus a
// randomized run, all compared against a channel-list reference model.
module tb_mux_select_scanner;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [3:0] mask = '0;
  logic [7:0] dwell = '0;
  logic       continuous = 1'b0;
  logic [1:0] s;
  logic       valid, busy, sweep_done, err;

  int passed = 0;
  int total  = 0;

  mux_select_scanner #(.DWELL_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .stop       (stop),
    .mask       (mask),
    .dwell      (dwell),
    .continuous (continuous),
    .s          (s),
    .valid      (valid),
    .busy       (busy),
    .sweep_done (sweep_done),
    .err        (err)
  );

  always #5 clk = ~clk;

  wire [5:0] got = {s, valid, busy, sweep_done, err};

  // Reference model: ordered list of enabled channels, a position in it and
  // the number of cycles still to spend on the current channel.
  int   m_ch[$];
  int   m_pos, m_left, m_dw;
  bit   m_busy, m_cont;
  logic [5:0] expv;

  function automatic void model_reset();
    m_ch.delete();
    m_pos = 0; m_left = 0; m_dw = 1;
    m_busy = 0; m_cont = 0;
    expv = '0;
  endfunction

  task automatic step(input logic st, input logic sp, input logic [3:0] mk,
                      input logic [7:0] dw, input logic ct);
    bit e_done, e_err;
    int cur;
    @(negedge clk);
    start = st; stop = sp; mask = mk; dwell = dw; continuous = ct;
    @(posedge clk);
    e_done = 0; e_err = 0;
    if (!m_busy) begin
      if (st) begin
        if (mk == 0) e_err = 1;
        else begin
          m_ch.delete();
          for (int i = 0; i < 4; i++) if (mk[i]) m_ch.push_back(i);
          m_pos  = 0;
          m_dw   = (dw == 0) ? 1 : int'(dw);
          m_left = m_dw;
          m_cont = ct;
          m_busy = 1;
        end
      end
    end else if (sp) begin
      m_busy = 0;
    end else begin
      m_left--;
      if (m_left == 0) begin
        m_pos++;
        m_left = m_dw;
        if (m_pos == m_ch.size()) begin
          e_done = 1;
          if (m_cont) m_pos = 0;
          else m_busy = 0;
        end
      end
    end
    cur  = m_busy ? m_ch[m_pos] : 0;
    expv = {2'(cur), m_busy, m_busy, e_done, e_err};
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    #3;
    total++;
    if (got !== 6'b0) $display("FAIL reset_state got=%b exp=%b", got, 6'b0);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_one_shot_1011();
    int s_seq[6] = '{0, 0, 1, 1, 3, 3};
    int dones = 0;
    for (int c = 0; c < 9; c++) begin
      if (c == 0) step(1, 0, 4'b1011, 8'd2, 0);
      else        step(0, 0, 4'b0000, 8'd0, 0);
      total++;
      if (got !== expv) $display("FAIL one_shot_model c=%0d got=%b exp=%b", c, got, expv);
      else passed++;
      if (c < 6) begin
        total++;
        if (int'(s) !== s_seq[c] || valid !== 1'b1)
          $display("FAIL one_shot_seq c=%0d got s=%0d v=%b exp s=%0d v=1", c, s, valid, s_seq[c]);
        else passed++;
      end
      if (sweep_done) dones++;
    end
    total++;
    if (dones != 1 || busy !== 1'b0 || s !== 2'd0)
      $display("FAIL one_shot_end got done=%0d busy=%b s=%0d exp done=1 busy=0 s=0", dones, busy, s);
    else passed++;
  endtask

  task automatic test_single_cont();
    step(1, 0, 4'b0100, 8'd0, 1);
    for (int c = 0; c < 6; c++) begin
      step(0, 0, 4'b0000, 8'd0, 0);
      total++;
      if (got !== expv || s !== 2'd2 || sweep_done !== 1'b1)
        $display("FAIL single_cont c=%0d got=%b exp=%b", c, got, expv);
      else passed++;
    end
    step(0, 1, 4'b0000, 8'd0, 0);
    total++;
    if (got !== expv || busy !== 1'b0 || sweep_done !== 1'b0)
      $display("FAIL single_cont_stop got=%b exp=%b", got, expv);
    else passed++;
  endtask

  task automatic test_err();
    step(1, 0, 4'b0000, 8'd3, 1);
    total++;
    if (got !== expv || err !== 1'b1 || busy !== 1'b0)
      $display("FAIL err_pulse got=%b exp=%b", got, expv);
    else passed++;
    step(0, 0, 4'b0000, 8'd0, 0);
    total++;
    if (got !== expv || err !== 1'b0)
      $display("FAIL err_clear got=%b exp=%b", got, expv);
    else passed++;
  endtask

  task automatic test_stop_on_expiry();
    bit hit = 0;
    step(1, 0, 4'b1111, 8'd3, 1);
    for (int c = 0; c < 30 && !hit; c++) begin
      if (m_busy && m_ch[m_pos] == 3 && m_left == 1) hit = 1;
      else begin
        step(0, 0, 4'b0000, 8'd0, 0);
        total++;
        if (got !== expv) $display("FAIL stop_exp_run c=%0d got=%b exp=%b", c, got, expv);
        else passed++;
      end
    end
    total++;
    if (!hit) $display("FAIL stop_exp_reach got=timeout exp=last_cycle_on_ch3");
    else begin
      step(0, 1, 4'b0000, 8'd0, 0);
      if (got !== expv || sweep_done !== 1'b0 || valid !== 1'b0 || busy !== 1'b0)
        $display("FAIL stop_exp_abort got=%b exp=%b", got, expv);
      else passed++;
    end
  endtask

  task automatic test_async_reset();
    step(1, 0, 4'b0100, 8'd5, 0);
    step(0, 0, 4'b0000, 8'd0, 0);
    total++;
    if (got !== expv || s !== 2'd2) $display("FAIL areset_pre got=%b exp=%b", got, expv);
    else passed++;
    rst_n = 1'b0;
    model_reset();
    #1;
    total++;
    if (got !== 6'b0) $display("FAIL areset_now got=%b exp=%b", got, 6'b0);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 0, 4'b1000, 8'd1, 0);
    total++;
    if (got !== expv || s !== 2'd3 || valid !== 1'b1)
      $display("FAIL areset_restart got=%b exp=%b", got, expv);
    else passed++;
    step(0, 1, 4'b0000, 8'd0, 0);
  endtask

  task automatic test_ignore_changes();
    bit bad = 0;
    step(1, 0, 4'b0011, 8'd2, 1);
    for (int c = 0; c < 12; c++) begin
      if (c == 3) step(1, 0, 4'b1100, 8'd7, 0);
      else        step(0, 0, 4'b1100, 8'd7, 0);
      total++;
      if (got !== expv) $display("FAIL ignore_model c=%0d got=%b exp=%b", c, got, expv);
      else passed++;
      if (s > 2'd1 || valid !== 1'b1) bad = 1;
    end
    total++;
    if (bad) $display("FAIL ignore_channels got=left_ch0_1 exp=only_ch0_1");
    else passed++;
    step(0, 1, 4'b0000, 8'd0, 0);
  endtask

  task automatic test_start_stop_idle();
    step(1, 1, 4'b0010, 8'd1, 0);
    total++;
    if (got !== expv || busy !== 1'b1 || s !== 2'd1)
      $display("FAIL start_stop_idle got=%b exp=%b", got, expv);
    else passed++;
    step(0, 0, 4'b0000, 8'd0, 0);
    total++;
    if (got !== expv || sweep_done !== 1'b1)
      $display("FAIL start_stop_done got=%b exp=%b", got, expv);
    else passed++;
  endtask

  task automatic test_back_to_back();
    step(1, 0, 4'b0110, 8'd1, 0);
    step(0, 0, 4'b0000, 8'd0, 0);
    step(1, 0, 4'b1001, 8'd2, 0);
    for (int c = 0; c < 6; c++) begin
      step(0, 0, 4'b0000, 8'd0, 0);
      total++;
      if (got !== expv) $display("FAIL back_to_back c=%0d got=%b exp=%b", c, got, expv);
      else passed++;
    end
  endtask

  task automatic test_random();
    logic [3:0] mk;
    for (int c = 0; c < 400; c++) begin
      mk = 4'($urandom);
      if ($urandom_range(7) == 0) mk = 4'b0000;
      step($urandom_range(3) == 0, $urandom_range(15) == 0, mk,
           8'($urandom_range(4)), 1'($urandom));
      total++;
      if (got !== expv) $display("FAIL random c=%0d got=%b exp=%b", c, got, expv);
      else passed++;
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_one_shot_1011();
    test_single_cont();
    test_err();
    test_stop_on_expiry();
    test_async_reset();
    test_ignore_changes();
    test_start_stop_idle();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
